sd_digit_serializer: RTL and testbench

Converts packed signed-digit words (NUM_DIGITS digits per word, each digit a plus/minus bit pair) back into a serial stream of one redundant digit per cycle, most significant digit first. It is the read-side counterpart of the digit-packing RAM front end: the divider's Newton iteration datapath hands it complete x/p words, and it feeds the online (MSD-first) arithmetic units that consume one digit per clock. Input and output are valid/ready handshakes with a two-word holding structure, so full throughput is sustained with no bubble between words.

---
 rtl/sd_pkg.sv | 27 ++
 rtl/sd_word_slot.sv | 47 ++++
 rtl/sd_digit_serializer.sv | 150 +++++++++++++++
 tb/tb_sd_digit_serializer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the signed-digit serializer: digit encodings, FSM states, default width.
package sd_pkg;

  localparam int unsigned SD_NUM_DIGITS = 4;

  localparam logic [1:0] SD_ZERO    = 2'b00;
  localparam logic [1:0] SD_MINUS   = 2'b01;
  localparam logic [1:0] SD_PLUS    = 2'b10;
  localparam logic [1:0] SD_ILLEGAL = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } sd_state_e;

  // Map the illegal both-set encoding to zero; legal digits pass unchanged.
  function automatic logic [1:0] sd_sanitize(input logic [1:0] d);
    logic [1:0] r;
    r = SD_ZERO;
    case (d)
      SD_ZERO, SD_MINUS, SD_PLUS: r = d;
      default:                    r = SD_ZERO;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sd_word_slot.sv
// PEND holding register: one packed signed-digit word plus last flag and valid bit.
module sd_word_slot
  import sd_pkg::*;
#(
  parameter int unsigned W = SD_NUM_DIGITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] plus_i,
  input  logic [W-1:0] minus_i,
  input  logic         last_i,
  output logic [W-1:0] plus_o,
  output logic [W-1:0] minus_o,
  output logic         last_o,
  output logic         valid_o
);

  logic [W-1:0] plus_q;
  logic [W-1:0] minus_q;
  logic         last_q;
  logic         valid_q;

  // A load on the same edge as a clear keeps the slot full with the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      plus_q  <= '0;
      minus_q <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      plus_q  <= plus_i;
      minus_q <= minus_i;
      last_q  <= last_i;
      valid_q <= 1'b1;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign plus_o  = plus_q;
  assign minus_o = minus_q;
  assign last_o  = last_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/sd_digit_serializer.sv
// Packed signed-digit word to MSD-first serial digit stream with a two-word (PEND + CUR) buffer.
// Optional illegal-digit check and substitution enabled by defining SD_DIGIT_CHECK_EN.
module sd_digit_serializer
  import sd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = SD_NUM_DIGITS,
  parameter int unsigned CNT_W      = 9,
  parameter int unsigned WCNT_W     = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          read_enable,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_DIGITS-1:0]         in_plus,
  input  logic [NUM_DIGITS-1:0]         in_minus,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [1:0]                    out_digit,
  output logic [$clog2(NUM_DIGITS)-1:0] out_sel,
  output logic                          out_last,
  output logic [CNT_W-1:0]              digit_cnt,
  output logic [WCNT_W-1:0]             word_cnt,
  output logic                          error_flag
);

  localparam int unsigned SEL_W = $clog2(NUM_DIGITS);
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_DIGITS - 1);

  logic [NUM_DIGITS-1:0] pend_plus;
  logic [NUM_DIGITS-1:0] pend_minus;
  logic                  pend_last;
  logic                  pend_valid;

  sd_state_e             state_q;
  logic [NUM_DIGITS-1:0] cur_plus_q;
  logic [NUM_DIGITS-1:0] cur_minus_q;
  logic                  cur_last_q;
  logic [SEL_W-1:0]      sel_q;
  logic [CNT_W-1:0]      digit_cnt_q;
  logic [WCNT_W-1:0]     word_cnt_q;

  logic       sel_at_max;
  logic       in_fire;
  logic       out_fire;
  logic       load_cur;
  logic [1:0] raw_digit;

  // Handshakes are suppressed entirely while the block is frozen.
  assign in_ready   = read_enable & ~pend_valid;
  assign out_valid  = read_enable & (state_q == ST_SHIFT);
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign sel_at_max = (sel_q == SEL_MAX);
  assign load_cur   = read_enable & pend_valid &
                      ((state_q == ST_IDLE) | (out_fire & sel_at_max));

  sd_word_slot #(.W(NUM_DIGITS)) u_pend (
    .clk     (clk),
    .rst     (rst),
    .load_i  (in_fire),
    .clear_i (load_cur),
    .plus_i  (in_plus),
    .minus_i (in_minus),
    .last_i  (in_last),
    .plus_o  (pend_plus),
    .minus_o (pend_minus),
    .last_o  (pend_last),
    .valid_o (pend_valid)
  );

  // CUR shift register and FSM; the current digit always sits at the MSB position.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_plus_q  <= '0;
      cur_minus_q <= '0;
      cur_last_q  <= 1'b0;
      sel_q       <= '0;
      digit_cnt_q <= '0;
      word_cnt_q  <= '0;
    end else if (read_enable) begin
      if (out_fire) begin
        digit_cnt_q <= digit_cnt_q + CNT_W'(1);
      end
      if (out_fire && sel_at_max) begin
        word_cnt_q <= word_cnt_q + WCNT_W'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (load_cur) begin
            cur_plus_q  <= pend_plus;
            cur_minus_q <= pend_minus;
            cur_last_q  <= pend_last;
            sel_q       <= '0;
            state_q     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (out_fire) begin
            if (sel_at_max && load_cur) begin
              cur_plus_q  <= pend_plus;
              cur_minus_q <= pend_minus;
              cur_last_q  <= pend_last;
              sel_q       <= '0;
            end else if (sel_at_max) begin
              cur_plus_q  <= {cur_plus_q[NUM_DIGITS-2:0], 1'b0};
              cur_minus_q <= {cur_minus_q[NUM_DIGITS-2:0], 1'b0};
              cur_last_q  <= 1'b0;
              sel_q       <= '0;
              state_q     <= ST_IDLE;
            end else begin
              cur_plus_q  <= {cur_plus_q[NUM_DIGITS-2:0], 1'b0};
              cur_minus_q <= {cur_minus_q[NUM_DIGITS-2:0], 1'b0};
              sel_q       <= sel_q + SEL_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign raw_digit = {cur_plus_q[NUM_DIGITS-1], cur_minus_q[NUM_DIGITS-1]};
  assign out_sel   = sel_q;
  assign out_last  = cur_last_q & sel_at_max;
  assign digit_cnt = digit_cnt_q;
  assign word_cnt  = word_cnt_q;

`ifdef SD_DIGIT_CHECK_EN
  logic error_flag_q;

  // Sticky flag raised when an illegal digit is actually consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      error_flag_q <= 1'b0;
    end else if (out_fire && (raw_digit == SD_ILLEGAL)) begin
      error_flag_q <= 1'b1;
    end
  end

  assign out_digit  = sd_sanitize(raw_digit);
  assign error_flag = error_flag_q;
`else
  assign out_digit  = raw_digit;
  assign error_flag = 1'b0;
`endif

endmodule

// File: tb/tb_sd_digit_serializer.sv
// Scoreboard bench for sd_digit_serializer: accepted words expand into expected digit entries,
// a negedge monitor checks handshake timing, digits, counters and the error flag.
module tb_sd_digit_serializer;

  localparam int N      = 4;
  localparam int CNT_W  = 9;
  localparam int WCNT_W = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             read_enable = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_plus = '0;
  logic [N-1:0]     in_minus = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [1:0]       out_digit;
  logic [1:0]       out_sel;
  logic             out_last;
  logic [CNT_W-1:0] digit_cnt;
  logic [WCNT_W-1:0] word_cnt;
  logic             error_flag;

  sd_digit_serializer #(.NUM_DIGITS(N), .CNT_W(CNT_W), .WCNT_W(WCNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .read_enable (read_enable),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_plus     (in_plus),
    .in_minus    (in_minus),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_digit   (out_digit),
    .out_sel     (out_sel),
    .out_last    (out_last),
    .digit_cnt   (digit_cnt),
    .word_cnt    (word_cnt),
    .error_flag  (error_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] dig;
    int         sel;
    bit         last;
    bit         ill;
    int         t;
  } exp_t;

  exp_t              exp_q[$];
  int                k = 0;
  int                n_checks = 0;
  int                n_fail = 0;
  logic [CNT_W-1:0]  m_dcnt = '0;
  logic [WCNT_W-1:0] m_wcnt = '0;
  bit                m_err = 1'b0;
  bit                rnd_rdy = 1'b0;
  bit                rnd_en = 1'b0;
  int                nw;
  bit                hr;
  exp_t              popped;

`ifdef SD_DIGIT_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word is N digits, MSD first; illegal digits become zero when checking is on.
  function automatic void push_word(input logic [N-1:0] p, input logic [N-1:0] m,
                                    input bit l, input int t);
    exp_t e;
    logic [1:0] raw;
    for (int i = 0; i < N; i++) begin
      raw   = {p[N-1-i], m[N-1-i]};
      e.ill = (raw == 2'b11);
      e.dig = (CHECK_ON && e.ill) ? 2'b00 : raw;
      e.sel = i;
      e.last = l && (i == N - 1);
      e.t   = t;
      exp_q.push_back(e);
    end
  endfunction

  // Monitor: a word accepted at enabled cycle t is in CUR from cycle t+2; PEND is full
  // whenever two words are outstanding or the only one has not yet moved to CUR.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_dcnt = '0;
      m_wcnt = '0;
      m_err  = 1'b0;
    end else begin
      nw = (exp_q.size() + N - 1) / N;
      hr = (exp_q.size() > 0) && (exp_q[0].t + 2 <= k);
      chk("out_valid", out_valid, read_enable && hr);
      chk("in_ready", in_ready, read_enable && !(nw >= 2 || (nw == 1 && !hr)));
      chk("digit_cnt", digit_cnt, m_dcnt);
      chk("word_cnt", word_cnt, m_wcnt);
      chk("error_flag", error_flag, m_err);
      if (hr) begin
        chk("out_digit", out_digit, exp_q[0].dig);
        chk("out_sel", out_sel, exp_q[0].sel);
        chk("out_last", out_last, exp_q[0].last);
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        popped = exp_q.pop_front();
        m_dcnt++;
        if (popped.sel == N - 1) m_wcnt++;
        if (CHECK_ON && popped.ill) m_err = 1'b1;
      end
      if (in_valid && in_ready) push_word(in_plus, in_minus, in_last, k);
      if (read_enable) k++;
    end
  end

  task automatic send_word(input logic [N-1:0] p, input logic [N-1:0] m, input bit l);
    bit got;
    in_plus  = p;
    in_minus = m;
    in_last  = l;
    in_valid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      if (got) begin
        in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        @(negedge clk);
        return;
      end
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_digit"}, out_digit, 0);
    chk({tag, "_out_sel"}, out_sel, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_digit_cnt"}, digit_cnt, 0);
    chk({tag, "_word_cnt"}, word_cnt, 0);
    chk({tag, "_error_flag"}, error_flag, 0);
  endtask

  // Background randomisers for the soak phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
      if (rnd_en) read_enable = ($urandom_range(0, 7) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] p, m;
    bit found;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");

    // Single framed word.
    @(posedge clk);
    #1 out_ready = 1'b1;
    send_word(4'b1010, 4'b0100, 1'b1);
    wait_drain();
    chk("t1_word_cnt", word_cnt, 1);
    chk("t1_digit_cnt", digit_cnt, 4);

    // Three back-to-back words.
    for (int i = 0; i < 3; i++) begin
      p = N'($urandom);
      m = N'($urandom) & ~p;
      send_word(p, m, i == 2);
    end
    wait_drain();

    // Stall mid-word while PEND fills.
    fork
      begin
        send_word(4'b1100, 4'b0011, 1'b0);
        send_word(4'b0110, 4'b1001, 1'b0);
        send_word(4'b0001, 4'b0100, 1'b1);
      end
      begin
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
          @(posedge clk);
          #1 found = out_valid;
        end
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(posedge clk); #1 out_ready = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Freeze for five cycles mid-word.
    fork
      begin
        send_word(4'b1011, 4'b0100, 1'b0);
        send_word(4'b0101, 4'b1010, 1'b1);
      end
      begin
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
          @(posedge clk);
          #1 found = out_valid && (out_sel == 2'd1);
        end
        chk("freeze_reached", found, 1);
        read_enable = 1'b0;
        repeat (5) @(posedge clk);
        #1 read_enable = 1'b1;
      end
    join
    wait_drain();

    // Reset mid-word at digit index 2.
    fork
      send_word(4'b1111, 4'b0000, 1'b1);
      begin
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
          @(posedge clk);
          #1 found = out_valid && (out_sel == 2'd2);
        end
        chk("rst_reached", found, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    @(negedge clk);
    chk_reset_state("midrst");
    send_word(4'b1000, 4'b0001, 1'b1);
    wait_drain();

    // Illegal digit in third position.
    send_word(4'b0010, 4'b0010, 1'b0);
    wait_drain();
    chk("illegal_error_flag", error_flag, CHECK_ON);

    // Randomised soak with back-pressure and freezes.
    rnd_rdy = 1'b1;
    rnd_en  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      p = N'($urandom);
      m = ($urandom_range(0, 4) == 0) ? N'($urandom) : (N'($urandom) & ~p);
      send_word(p, m, $urandom_range(0, 1) == 1);
    end
    rnd_en = 1'b0;
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2;
    read_enable = 1'b1;
    out_ready = 1'b1;
    wait_drain();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
